// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a LEN/words/CHK byte stream into 16-bit instruction memory writes
module instr_mem_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              load_done,
    output logic              chk_err,
    output logic [7:0]        words_loaded
);
    typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, CHK} state_t;
    state_t     state, nxt;
    logic [7:0] idx, count, xsum, hi;
    logic       acc;
    assign acc = in_valid && in_ready;
    // next state; in_ready is a registered decode of state, so acc needs no state qualifier
    always_comb begin
        nxt = state == IDLE ? (start ? LEN : IDLE)
            : state == LEN  ? (acc ? (in_data == 8'd0 ? CHK : HI) : LEN)
            : state == HI   ? (acc ? LO : HI)
            : state == LO   ? (acc ? WR : LO)
            : state == WR   ? (idx + 8'd1 == count ? CHK : HI)
            : state == CHK  ? (acc ? IDLE : CHK)
            : IDLE;
    end
    // state, registered handshake/status outputs and datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_hold    <= 1'b0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
            chk_err      <= 1'b0;
            words_loaded <= '0;
            idx          <= '0;
            count        <= '0;
            xsum         <= '0;
            hi           <= '0;
        end else begin
            state     <= nxt;
            in_ready  <= nxt == LEN || nxt == HI || nxt == LO || nxt == CHK;
            mem_we    <= nxt == WR;
            busy      <= nxt != IDLE;
            core_hold <= nxt != IDLE;
            if (state == IDLE && start) begin
                idx          <= '0;
                xsum         <= '0;
                words_loaded <= '0;
                load_done    <= 1'b0;
                chk_err      <= 1'b0;
            end
            if (state == LEN && acc)
                count <= in_data;
            if (state == HI && acc) begin
                hi   <= in_data;
                xsum <= xsum ^ in_data;
            end
            // address and word are captured on the low-byte accept so they are valid throughout WR
            if (state == LO && acc) begin
                xsum      <= xsum ^ in_data;
                mem_wdata <= {hi, in_data};
                mem_addr  <= BASE_ADDR + ADDR_W'(idx);
            end
            if (state == WR) begin
                idx          <= idx + 8'd1;
                words_loaded <= words_loaded + 8'd1;
            end
            if (state == CHK && acc) begin
                chk_err   <= in_data != xsum;
                load_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of stream packing, checksum, wrap and reset abort
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, core_hold, busy, load_done, chk_err;
    logic [7:0]  mem_addr, words_loaded;
    logic [15:0] mem_wdata;
    logic        in_ready_b, mem_we_b, core_hold_b, busy_b, load_done_b, chk_err_b;
    logic [7:0]  mem_addr_b, words_loaded_b;
    logic [15:0] mem_wdata_b;
    logic [23:0] wq[$];
    logic [23:0] wq_b[$];
    logic [7:0]  strm[0:15];
    int          n_chk = 0;
    int          n_fail = 0;
    int          rdy_viol = 0;

    instr_mem_loader u0 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .busy(busy), .load_done(load_done), .chk_err(chk_err),
        .words_loaded(words_loaded)
    );

    instr_mem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) u1 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .core_hold(core_hold_b), .busy(busy_b), .load_done(load_done_b), .chk_err(chk_err_b),
        .words_loaded(words_loaded_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wq.push_back({mem_addr, mem_wdata});
            if (in_ready) rdy_viol++;
        end
        if (mem_we_b) wq_b.push_back({mem_addr_b, mem_wdata_b});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        if (with_start) start = 1'b1;
        for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
        if (!in_ready) check("ready_wait", {31'd0, in_ready}, 32'd1);
        else begin
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_load(input int n, input bit rnd, input bit chk_start);
        wq.delete();
        wq_b.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_on", {31'd0, core_hold}, 32'd1);
        check("done_clr", {30'd0, load_done, chk_err}, 32'd0);
        for (int i = 0; i < n; i++)
            send_byte(strm[i], rnd ? ((i % 2 == 1 && i >= 3) ? 0 : int'($urandom_range(0, 3))) : 0,
                      chk_start && i == n - 1);
        in_valid = 1'b0;
    endtask

    task automatic set_t1(input logic [7:0] chk);
        strm[0] = 8'h02; strm[1] = 8'h12; strm[2] = 8'h34;
        strm[3] = 8'hA5; strm[4] = 8'hFF; strm[5] = chk;
    endtask

    task automatic check_t1(input string t);
        check({t, "_nwr"}, wq.size(), 2);
        check({t, "_w0"}, wq[0], 24'h001234);
        check({t, "_w1"}, wq[1], 24'h01A5FF);
        check({t, "_done"}, {31'd0, load_done}, 1);
        check({t, "_err"}, {31'd0, chk_err}, 0);
        check({t, "_words"}, words_loaded, 2);
        check({t, "_hold_off"}, {30'd0, core_hold, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_flags", {26'd0, in_ready, mem_we, core_hold, busy, load_done, chk_err}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_words", words_loaded, 0);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_busy_after_start", {31'd0, busy}, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        set_t1(8'h7C);
        run_load(6, 1'b0, 1'b0);
        check_t1("t1");
        check("t1_addr_hold", mem_addr, 8'h01);
        check("t1_wdata_hold", mem_wdata, 16'hA5FF);

        set_t1(8'h00);
        run_load(6, 1'b0, 1'b1);
        check("t2_nwr", wq.size(), 2);
        check("t2_w1", wq[1], 24'h01A5FF);
        check("t2_err", {31'd0, chk_err}, 1);
        check("t2_done", {31'd0, load_done}, 1);
        check("t2_idle", {31'd0, busy}, 0);

        strm[0] = 8'h00; strm[1] = 8'h00;
        run_load(2, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("t3_nwr", wq.size(), 0);
        check("t3_done", {31'd0, load_done}, 1);
        check("t3_err", {31'd0, chk_err}, 0);
        check("t3_words", words_loaded, 0);

        set_t1(8'h7C);
        rdy_viol = 0;
        run_load(6, 1'b1, 1'b0);
        check_t1("t4");
        check("t4_ready_in_wr", rdy_viol, 0);

        strm[0] = 8'h03; strm[1] = 8'h01; strm[2] = 8'h02; strm[3] = 8'h03;
        strm[4] = 8'h04; strm[5] = 8'h05; strm[6] = 8'h06; strm[7] = 8'h07;
        run_load(8, 1'b0, 1'b0);
        check("t5_nwr", wq_b.size(), 3);
        check("t5_w0", wq_b[0], 24'hFE0102);
        check("t5_w1", wq_b[1], 24'hFF0304);
        check("t5_w2", wq_b[2], 24'h000506);
        check("t5_err", {30'd0, load_done_b, chk_err_b}, 32'd2);

        set_t1(8'h7C);
        wq.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(strm[i], 0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_first_wr", wq.size(), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_start_ignored", {23'd0, busy, words_loaded}, 32'h101);
        reset = 1'b0;
        #1;
        check("t6_rst_flags", {26'd0, in_ready, mem_we, core_hold, busy, load_done, chk_err}, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_wdata", mem_wdata, 0);
        check("t6_rst_words", words_loaded, 0);
        @(negedge clk);
        reset = 1'b1;
        run_load(6, 1'b0, 1'b0);
        check_t1("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
